// File: rtl/abs_nch_if.sv
// Bundle of the per-sample control, data and result signals for abs_nch.
// The master side drives the bitstreams, the slave side is the design.
interface abs_nch_if #(
  parameter int unsigned CH = 4
);
  logic          clr;
  logic          en;
  logic [1:0]    mode;
  logic [CH-1:0] value;
  logic          out_valid;
  logic [CH-1:0] out;
  logic [CH-1:0] sign;

  modport master (
    output clr, en, mode, value,
    input  out_valid, out, sign
  );

  modport slave (
    input  clr, en, mode, value,
    output out_valid, out, sign
  );
endinterface

// File: rtl/abs_nch.sv
// Multi-channel stochastic bipolar abs/ReLU/pass/negate unit.
// Each channel tracks its stream sign with a saturating up/down counter.
module abs_nch #(
  parameter int unsigned CH  = 4,
  parameter int unsigned DEP = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  abs_nch_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_ABS  = 2'b00,
    MODE_RELU = 2'b01,
    MODE_PASS = 2'b10,
    MODE_NEG  = 2'b11
  } mode_e;

  localparam logic [DEP-1:0] MID = {1'b1, {(DEP-1){1'b0}}};
  localparam logic [DEP-1:0] MAX = '1;
  localparam logic [DEP-1:0] ONE = {{(DEP-1){1'b0}}, 1'b1};

  logic [DEP-1:0] cnt [CH];
  logic           z;
  logic [CH-1:0]  s;
  logic [CH-1:0]  r;
  logic [CH-1:0]  out_q;
  logic [CH-1:0]  sign_q;
  logic           valid_q;
  mode_e          mode_sel;

  assign mode_sel = mode_e'(bus.mode);

  // Sign and result both come from the counter value before this sample's update.
  always_comb begin
    s = '0;
    r = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      s[i] = ~cnt[i][DEP-1];
      unique case (mode_sel)
        MODE_ABS:  r[i] = bus.value[i] ^ s[i];
        MODE_RELU: r[i] = s[i] ? z : bus.value[i];
        MODE_PASS: r[i] = bus.value[i];
        MODE_NEG:  r[i] = ~bus.value[i];
        default:   r[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH; i++) cnt[i] <= MID;
      z       <= 1'b0;
      out_q   <= '0;
      sign_q  <= '0;
      valid_q <= 1'b0;
    end else if (bus.clr) begin
      for (int unsigned i = 0; i < CH; i++) cnt[i] <= MID;
      z       <= 1'b0;
      out_q   <= '0;
      sign_q  <= '0;
      valid_q <= 1'b0;
    end else if (bus.en) begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (bus.value[i] && (cnt[i] != MAX))
          cnt[i] <= cnt[i] + ONE;
        else if (!bus.value[i] && (cnt[i] != '0))
          cnt[i] <= cnt[i] - ONE;
      end
      z       <= ~z;
      out_q   <= r;
      sign_q  <= s;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out       = out_q;
  assign bus.sign      = sign_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_abs_nch.sv
// Randomized and directed checks of abs_nch against a saturating-integer model.
module tb_abs_nch;

  localparam int unsigned CH  = 4;
  localparam int unsigned DEP = 3;
  localparam int          MID = 1 << (DEP - 1);
  localparam int          MAX = (1 << DEP) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  abs_nch_if #(.CH(CH)) bus ();

  abs_nch #(.CH(CH), .DEP(DEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;

  int          m_cnt [CH];
  bit          m_z;
  logic [CH-1:0] e_out, e_sign;
  logic        e_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) m_cnt[i] = MID;
    m_z = 0; e_out = '0; e_sign = '0; e_valid = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit e, input logic [1:0] md, input logic [CH-1:0] v);
    bit s, r;
    if (c) begin
      model_reset();
    end else if (e) begin
      for (int i = 0; i < CH; i++) begin
        s = (m_cnt[i] < MID);
        case (md)
          2'b00:   r = v[i] ^ s;
          2'b01:   r = s ? m_z : v[i];
          2'b10:   r = v[i];
          default: r = ~v[i];
        endcase
        e_out[i]  = r;
        e_sign[i] = s;
        m_cnt[i]  = v[i] ? ((m_cnt[i] + 1 > MAX) ? MAX : m_cnt[i] + 1)
                         : ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1);
      end
      m_z = ~m_z;
      e_valid = 1'b1;
    end else begin
      e_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(bus.out_valid), 32'(e_valid));
    check("out",       32'(bus.out),       32'(e_out));
    check("sign",      32'(bus.sign),      32'(e_sign));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare #1 later.
  task automatic step(input bit c, input bit e, input logic [1:0] md, input logic [CH-1:0] v);
    bus.clr = c; bus.en = e; bus.mode = md; bus.value = v;
    @(posedge clk);
    model_step(c, e, md, v);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [CH-1:0] rv;
  int ones [CH];
  int samples;
  real dens, bip, tgt;
  int p_tab [3] = '{100, 500, 900};
  bit ok;

  initial begin
    bus.clr = 0; bus.en = 0; bus.mode = 2'b00; bus.value = '0;
    do_reset();

    // Decrement toward zero: sign and abs output flip after the first sample.
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 2'b00, '0);
      check("dn_sign0", 32'(bus.sign[0]), (k == 0) ? 32'd0 : 32'd1);
      check("dn_out0",  32'(bus.out[0]),  (k == 0) ? 32'd0 : 32'd1);
    end

    // Increment to saturation and beyond.
    step(1, 0, 2'b00, '0);
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 2'b00, '1);
      check("up_sign0", 32'(bus.sign[0]), 32'd0);
      check("up_out0",  32'(bus.out[0]),  32'd1);
    end

    // ReLU with a negative counter outputs the zero-stream toggle.
    step(1, 0, 2'b00, '0);
    for (int k = 0; k < 4; k++) step(0, 1, 2'b00, '0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 2'b01, '0);
      check("relu_z", 32'(bus.out[0]), 32'(k % 2));
    end
    step(1, 0, 2'b00, '0);
    for (int k = 0; k < 4; k++) begin
      rv = CH'($urandom);
      step(0, 1, 2'b01, rv);
      check("relu_pos", 32'(bus.out[0]), 32'(rv[0]));
      step(0, 1, 2'b00, '1);
    end

    // en every other cycle.
    for (int k = 0; k < 6; k++) begin
      step(0, (k % 2) == 0, 2'b11, CH'($urandom));
      check("alt_valid", 32'(bus.out_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // clr together with en, counter at 1.
    step(1, 0, 2'b00, '0);
    for (int k = 0; k < 3; k++) step(0, 1, 2'b00, '0);
    step(1, 1, 2'b00, '1);
    check("clr_valid", 32'(bus.out_valid), 32'd0);
    step(0, 1, 2'b00, '0);
    check("clr_mid_sign", 32'(bus.sign[0]), 32'd0);

    // Asynchronous reset mid-cycle.
    step(0, 1, 2'b00, '1);
    step(0, 1, 2'b10, '1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_out",   32'(bus.out),       32'd0);
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_sign",  32'(bus.sign),      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 1, 2'b00, '0);
    check("post_rst_sign", 32'(bus.sign), 32'd0);

    // Fully random traffic.
    for (int k = 0; k < 2000; k++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom), CH'($urandom));

    // Bernoulli streams in abs mode: bipolar output magnitude tracks |2p-1|.
    foreach (p_tab[j]) begin
      step(1, 0, 2'b00, '0);
      for (int i = 0; i < CH; i++) ones[i] = 0;
      samples = 0;
      for (int k = 0; k < 4096; k++) begin
        for (int i = 0; i < CH; i++) rv[i] = ($urandom_range(0, 999) < p_tab[j]);
        step(0, 1, 2'b00, rv);
        samples++;
        for (int i = 0; i < CH; i++) ones[i] += int'(bus.out[i]);
      end
      tgt = (2.0 * p_tab[j] / 1000.0) - 1.0;
      if (tgt < 0.0) tgt = -tgt;
      for (int i = 0; i < CH; i++) begin
        dens = real'(ones[i]) / real'(samples);
        bip  = 2.0 * dens - 1.0;
        ok   = ((bip - tgt) <= 0.05) && ((tgt - bip) <= 0.05);
        check($sformatf("density_p%0d_ch%0d_x1000=%0d", p_tab[j], i, int'(bip * 1000.0)),
              32'(ok), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
